// File: rtl/scalar_issue_sched_if.sv
// IQ0 -> issue scheduler instruction handshake.
// Valid/ready: an instruction transfers on any cycle where in_valid and in_ready
// are both high at the rising clk edge. While in_valid is high and the transfer
// has not happened, the producer holds in_instr stable. in_ready is computed
// combinationally from in_instr (hazard check), so the producer must not make
// in_valid depend on in_ready.
interface scalar_issue_sched_if;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_ready;

   modport master (output in_valid, output in_instr, input in_ready);
   modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/scalar_issue_sched.sv
// Issue scheduler: feeds one instruction or NOP per cycle to the scalar core,
// stalls on RAW hazards the single WB->EX forwarding path cannot cover, and
// sequences core start-up and pipeline drain.
module scalar_issue_sched #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          RD_LSB    = 20,
   parameter int          RS1_LSB   = 16,
   parameter int          RS2_LSB   = 12,
   parameter int          MAX_AGE   = 2,
   parameter int          DRAIN_CYC = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   scalar_issue_sched_if.slave  iq,
   output logic [31:0]          issue_instr,
   output logic                 issue_bubble,
   output logic                 drained,
   output logic [15:0]          bubble_cnt,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // One issued slot: does it write a register, and which one.
   typedef struct packed {
      logic       wr;
      logic [3:0] rd;
   } hist_t;

   localparam int CW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

   state_e         state_q, state_d;
   hist_t          h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
   logic [CW-1:0]  drain_cnt_q, drain_cnt_d;
   logic [31:0]    issue_instr_q, issue_instr_d;
   logic           issue_bubble_q, issue_bubble_d;
   logic           drained_q, drained_d;
   logic [15:0]    bubble_cnt_q, bubble_cnt_d;

   logic [3:0] rd, rs1, rs2;
   logic       hit2, hit3, hazard, in_ready;

   assign rd  = iq.in_instr[RD_LSB  +: 4];
   assign rs1 = iq.in_instr[RS1_LSB +: 4];
   assign rs2 = iq.in_instr[RS2_LSB +: 4];

   // Producers at distance 2 (and 3 without regfile write-through) are out of
   // forwarding reach; distance 1 is forwarded WB->EX. S0 is never a dependency.
   assign hit2 = h2_q.wr && (h2_q.rd != 4'd0) && ((rs1 == h2_q.rd) || (rs2 == h2_q.rd));
   assign hit3 = h3_q.wr && (h3_q.rd != 4'd0) && ((rs1 == h3_q.rd) || (rs2 == h3_q.rd));
   assign hazard = hit2 || ((MAX_AGE == 3) && hit3);

   assign in_ready    = (state_q == ST_RUN) && enable && !hazard;
   assign iq.in_ready = in_ready;

   // Next-state, issue slot, history shift and bubble counting.
   always_comb begin
      state_d        = state_q;
      drain_cnt_d    = drain_cnt_q;
      issue_instr_d  = NOP_INSTR;
      issue_bubble_d = 1'b0;
      bubble_cnt_d   = bubble_cnt_q;
      h1_d           = '0;
      h2_d           = h1_q;
      h3_d           = h2_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = CW'(DRAIN_CYC - 1);
            end else if (iq.in_valid) begin
               if (hazard) begin
                  issue_bubble_d = 1'b1;
                  if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
               end else begin
                  issue_instr_d = iq.in_instr;
                  h1_d.wr       = (iq.in_instr != NOP_INSTR);
                  h1_d.rd       = rd;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q <= CW'(1)) state_d = ST_IDLE;
            if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - CW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      drained_d = (state_d == ST_IDLE);
   end

   // State and registered outputs; reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         h1_q           <= '0;
         h2_q           <= '0;
         h3_q           <= '0;
         drain_cnt_q    <= '0;
         issue_instr_q  <= NOP_INSTR;
         issue_bubble_q <= 1'b0;
         drained_q      <= 1'b1;
         bubble_cnt_q   <= 16'd0;
      end else begin
         state_q        <= state_d;
         h1_q           <= h1_d;
         h2_q           <= h2_d;
         h3_q           <= h3_d;
         drain_cnt_q    <= drain_cnt_d;
         issue_instr_q  <= issue_instr_d;
         issue_bubble_q <= issue_bubble_d;
         drained_q      <= drained_d;
         bubble_cnt_q   <= bubble_cnt_d;
      end
   end

   assign issue_instr  = issue_instr_q;
   assign issue_bubble = issue_bubble_q;
   assign drained      = drained_q;
   assign bubble_cnt   = bubble_cnt_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_scalar_issue_sched.sv
// Directed bench for scalar_issue_sched: one MAX_AGE=2 and one MAX_AGE=3 instance.
module tb_scalar_issue_sched;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [31:0] A   = 32'h0112_3000;  // rd1, rs 2/3
   localparam logic [31:0] B   = 32'h0145_6000;  // rd4, rs 5/6
   localparam logic [31:0] C   = 32'h0171_0000;  // rd7, rs 1/0
   localparam logic [31:0] Z   = 32'h0102_3000;  // rd0, rs 2/3
   localparam logic [31:0] R   = 32'h0120_0000;  // rd2, rs 0/0
   localparam logic [1:0]  S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

   typedef struct packed {
      logic        v;
      logic [31:0] x;
      logic        rdy;
      logic [31:0] iss;
      logic        bub;
      logic [15:0] cnt;
   } vec_t;

   typedef struct packed {
      logic        en;
      logic        v;
      logic [31:0] x;
      logic        rdy;
      logic [31:0] iss;
      logic        drn;
      logic [1:0]  st;
   } dvec_t;

   // A,B,C: C reads rd1 from A at distance 2 -> one bubble.
   localparam vec_t T_STALL [5] = '{
      '{1'b1, A,   1'b1, NOP, 1'b0, 16'd0},
      '{1'b1, B,   1'b1, A,   1'b0, 16'd0},
      '{1'b1, C,   1'b0, B,   1'b0, 16'd0},
      '{1'b1, C,   1'b1, NOP, 1'b1, 16'd1},
      '{1'b0, NOP, 1'b1, C,   1'b0, 16'd1}};

   // A,C forwarded; Z (rd0) then R reading S0 two slots later -> no bubble.
   localparam vec_t T_FWD [6] = '{
      '{1'b1, A,   1'b1, NOP, 1'b0, 16'd1},
      '{1'b1, C,   1'b1, A,   1'b0, 16'd1},
      '{1'b1, Z,   1'b1, C,   1'b0, 16'd1},
      '{1'b1, B,   1'b1, Z,   1'b0, 16'd1},
      '{1'b1, R,   1'b1, B,   1'b0, 16'd1},
      '{1'b0, NOP, 1'b1, R,   1'b0, 16'd1}};

   // MAX_AGE=3: A,B,C -> 2 bubbles; A,B,B,C -> 1 bubble; A,B,B,B,C -> none.
   localparam vec_t T_AGE3 [16] = '{
      '{1'b1, A,   1'b1, NOP, 1'b0, 16'd0},
      '{1'b1, B,   1'b1, A,   1'b0, 16'd0},
      '{1'b1, C,   1'b0, B,   1'b0, 16'd0},
      '{1'b1, C,   1'b0, NOP, 1'b1, 16'd1},
      '{1'b1, C,   1'b1, NOP, 1'b1, 16'd2},
      '{1'b1, A,   1'b1, C,   1'b0, 16'd2},
      '{1'b1, B,   1'b1, A,   1'b0, 16'd2},
      '{1'b1, B,   1'b1, B,   1'b0, 16'd2},
      '{1'b1, C,   1'b0, B,   1'b0, 16'd2},
      '{1'b1, C,   1'b1, NOP, 1'b1, 16'd3},
      '{1'b1, A,   1'b1, C,   1'b0, 16'd3},
      '{1'b1, B,   1'b1, A,   1'b0, 16'd3},
      '{1'b1, B,   1'b1, B,   1'b0, 16'd3},
      '{1'b1, B,   1'b1, B,   1'b0, 16'd3},
      '{1'b1, C,   1'b1, B,   1'b0, 16'd3},
      '{1'b0, NOP, 1'b1, C,   1'b0, 16'd3}};

   // Drop enable with B at the head: 3 NOPs after the last issue, drained on
   // the third, enable ignored while draining, B issues after re-enable.
   localparam dvec_t T_DRAIN [9] = '{
      '{1'b1, 1'b0, NOP, 1'b1, NOP, 1'b0, S_RUN},
      '{1'b1, 1'b1, A,   1'b1, NOP, 1'b0, S_RUN},
      '{1'b1, 1'b1, B,   1'b1, A,   1'b0, S_RUN},
      '{1'b0, 1'b1, B,   1'b0, B,   1'b0, S_RUN},
      '{1'b0, 1'b1, B,   1'b0, NOP, 1'b0, S_DRAIN},
      '{1'b1, 1'b1, B,   1'b0, NOP, 1'b0, S_DRAIN},
      '{1'b1, 1'b1, B,   1'b0, NOP, 1'b1, S_IDLE},
      '{1'b1, 1'b1, B,   1'b1, NOP, 1'b0, S_RUN},
      '{1'b1, 1'b0, NOP, 1'b1, B,   1'b0, S_RUN}};

   // Clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en2 = 1'b0;
   logic en3 = 1'b0;
   always #5 clk = ~clk;

   scalar_issue_sched_if if2 ();
   scalar_issue_sched_if if3 ();

   logic [31:0] iss2, iss3;
   logic        bub2, bub3, drn2, drn3;
   logic [15:0] cnt2, cnt3;
   logic [1:0]  st2, st3;

   scalar_issue_sched #(.MAX_AGE(2)) dut_a2 (
      .clk(clk), .rst(rst), .enable(en2), .iq(if2.slave),
      .issue_instr(iss2), .issue_bubble(bub2), .drained(drn2),
      .bubble_cnt(cnt2), .dbg_state(st2));

   scalar_issue_sched #(.MAX_AGE(3)) dut_a3 (
      .clk(clk), .rst(rst), .enable(en3), .iq(if3.slave),
      .issue_instr(iss3), .issue_bubble(bub3), .drained(drn3),
      .bubble_cnt(cnt3), .dbg_state(st3));

   int n_checks = 0;
   int n_fail   = 0;

   // Drivers: inputs change 1 ns after the rising edge, outputs read at the falling edge.
   task automatic drv2(input logic en, input logic v, input logic [31:0] x);
      @(posedge clk); #1;
      en2 = en; if2.in_valid = v; if2.in_instr = x;
      @(negedge clk);
   endtask

   task automatic drv3(input logic en, input logic v, input logic [31:0] x);
      @(posedge clk); #1;
      en3 = en; if3.in_valid = v; if3.in_instr = x;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (iss2 !== NOP)    begin n_fail++; $display("FAIL rst_issue2 got %h exp %h", iss2, NOP); end
      n_checks++; if (bub2 !== 1'b0)   begin n_fail++; $display("FAIL rst_bubble2 got %b exp 0", bub2); end
      n_checks++; if (if2.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready2 got %b exp 0", if2.in_ready); end
      n_checks++; if (drn2 !== 1'b1)   begin n_fail++; $display("FAIL rst_drained2 got %b exp 1", drn2); end
      n_checks++; if (cnt2 !== 16'd0)  begin n_fail++; $display("FAIL rst_cnt2 got %0d exp 0", cnt2); end
      n_checks++; if (st2 !== S_IDLE)  begin n_fail++; $display("FAIL rst_state2 got %0d exp %0d", st2, S_IDLE); end
      n_checks++; if (iss3 !== NOP || drn3 !== 1'b1 || cnt3 !== 16'd0)
         begin n_fail++; $display("FAIL rst_dut3 got iss=%h drn=%b cnt=%0d exp %h 1 0", iss3, drn3, cnt3, NOP); end
      rst = 1'b0;
   endtask

   task automatic test_hazard_stall();
      drv2(1'b1, 1'b0, NOP);
      n_checks++; if (if2.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_idle_ready got %b exp 0", if2.in_ready); end
      for (int i = 0; i < 5; i++) begin
         drv2(1'b1, T_STALL[i].v, T_STALL[i].x);
         n_checks++; if (if2.in_ready !== T_STALL[i].rdy) begin n_fail++; $display("FAIL stall_ready[%0d] got %b exp %b", i, if2.in_ready, T_STALL[i].rdy); end
         n_checks++; if (iss2 !== T_STALL[i].iss) begin n_fail++; $display("FAIL stall_issue[%0d] got %h exp %h", i, iss2, T_STALL[i].iss); end
         n_checks++; if (bub2 !== T_STALL[i].bub) begin n_fail++; $display("FAIL stall_bubble[%0d] got %b exp %b", i, bub2, T_STALL[i].bub); end
         n_checks++; if (cnt2 !== T_STALL[i].cnt) begin n_fail++; $display("FAIL stall_cnt[%0d] got %0d exp %0d", i, cnt2, T_STALL[i].cnt); end
      end
   endtask

   task automatic test_forwarding();
      for (int i = 0; i < 6; i++) begin
         drv2(1'b1, T_FWD[i].v, T_FWD[i].x);
         n_checks++; if (if2.in_ready !== T_FWD[i].rdy) begin n_fail++; $display("FAIL fwd_ready[%0d] got %b exp %b", i, if2.in_ready, T_FWD[i].rdy); end
         n_checks++; if (iss2 !== T_FWD[i].iss) begin n_fail++; $display("FAIL fwd_issue[%0d] got %h exp %h", i, iss2, T_FWD[i].iss); end
         n_checks++; if (bub2 !== T_FWD[i].bub) begin n_fail++; $display("FAIL fwd_bubble[%0d] got %b exp %b", i, bub2, T_FWD[i].bub); end
         n_checks++; if (cnt2 !== T_FWD[i].cnt) begin n_fail++; $display("FAIL fwd_cnt[%0d] got %0d exp %0d", i, cnt2, T_FWD[i].cnt); end
      end
   endtask

   task automatic test_age3();
      drv3(1'b1, 1'b0, NOP);
      for (int i = 0; i < 16; i++) begin
         drv3(1'b1, T_AGE3[i].v, T_AGE3[i].x);
         n_checks++; if (if3.in_ready !== T_AGE3[i].rdy) begin n_fail++; $display("FAIL age3_ready[%0d] got %b exp %b", i, if3.in_ready, T_AGE3[i].rdy); end
         n_checks++; if (iss3 !== T_AGE3[i].iss) begin n_fail++; $display("FAIL age3_issue[%0d] got %h exp %h", i, iss3, T_AGE3[i].iss); end
         n_checks++; if (bub3 !== T_AGE3[i].bub) begin n_fail++; $display("FAIL age3_bubble[%0d] got %b exp %b", i, bub3, T_AGE3[i].bub); end
         n_checks++; if (cnt3 !== T_AGE3[i].cnt) begin n_fail++; $display("FAIL age3_cnt[%0d] got %0d exp %0d", i, cnt3, T_AGE3[i].cnt); end
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 9; i++) begin
         drv2(T_DRAIN[i].en, T_DRAIN[i].v, T_DRAIN[i].x);
         n_checks++; if (if2.in_ready !== T_DRAIN[i].rdy) begin n_fail++; $display("FAIL drain_ready[%0d] got %b exp %b", i, if2.in_ready, T_DRAIN[i].rdy); end
         n_checks++; if (iss2 !== T_DRAIN[i].iss) begin n_fail++; $display("FAIL drain_issue[%0d] got %h exp %h", i, iss2, T_DRAIN[i].iss); end
         n_checks++; if (drn2 !== T_DRAIN[i].drn) begin n_fail++; $display("FAIL drain_drained[%0d] got %b exp %b", i, drn2, T_DRAIN[i].drn); end
         n_checks++; if (st2 !== T_DRAIN[i].st) begin n_fail++; $display("FAIL drain_state[%0d] got %0d exp %0d", i, st2, T_DRAIN[i].st); end
         n_checks++; if (bub2 !== 1'b0) begin n_fail++; $display("FAIL drain_bubble[%0d] got %b exp 0", i, bub2); end
      end
   endtask

   task automatic test_reset_midop();
      drv2(1'b1, 1'b1, A);
      drv2(1'b1, 1'b1, B);
      drv2(1'b1, 1'b1, C);
      n_checks++; if (if2.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_stall_ready got %b exp 0", if2.in_ready); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; en2 = 1'b1; if2.in_valid = 1'b1; if2.in_instr = C;
      @(negedge clk);
      n_checks++; if (iss2 !== NOP)   begin n_fail++; $display("FAIL midrst_issue got %h exp %h", iss2, NOP); end
      n_checks++; if (bub2 !== 1'b0)  begin n_fail++; $display("FAIL midrst_bubble got %b exp 0", bub2); end
      n_checks++; if (if2.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b exp 0", if2.in_ready); end
      n_checks++; if (drn2 !== 1'b1)  begin n_fail++; $display("FAIL midrst_drained got %b exp 1", drn2); end
      n_checks++; if (cnt2 !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt got %0d exp 0", cnt2); end
      n_checks++; if (st2 !== S_IDLE) begin n_fail++; $display("FAIL midrst_state got %0d exp %0d", st2, S_IDLE); end
      n_checks++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt3 got %0d exp 0", cnt3); end
      drv2(1'b1, 1'b1, C);
      n_checks++; if (if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_c_ready got %b exp 1", if2.in_ready); end
      n_checks++; if (iss2 !== NOP)   begin n_fail++; $display("FAIL midrst_c_prev got %h exp %h", iss2, NOP); end
      drv2(1'b1, 1'b0, NOP);
      n_checks++; if (iss2 !== C)     begin n_fail++; $display("FAIL midrst_c_issue got %h exp %h", iss2, C); end
      n_checks++; if (bub2 !== 1'b0 || cnt2 !== 16'd0) begin n_fail++; $display("FAIL midrst_c_bubble got bub=%b cnt=%0d exp 0 0", bub2, cnt2); end
   endtask

   task automatic test_saturation();
      force dut_a2.hazard = 1'b1;
      if2.in_valid = 1'b1;
      if2.in_instr = A;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      n_checks++; if (cnt2 !== 16'hFFFE) begin n_fail++; $display("FAIL sat_cnt_fffe got %h exp fffe", cnt2); end
      repeat (6) @(posedge clk);
      @(negedge clk);
      n_checks++; if (cnt2 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt_ffff got %h exp ffff", cnt2); end
      n_checks++; if (bub2 !== 1'b1 || iss2 !== NOP) begin n_fail++; $display("FAIL sat_bubble got bub=%b iss=%h exp 1 %h", bub2, iss2, NOP); end
      n_checks++; if (if2.in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready got %b exp 0", if2.in_ready); end
      release dut_a2.hazard;
      if2.in_valid = 1'b0;
      if2.in_instr = NOP;
   endtask

   initial begin
      if2.in_valid = 1'b0; if2.in_instr = NOP;
      if3.in_valid = 1'b0; if3.in_instr = NOP;
      test_reset();
      test_hazard_stall();
      test_forwarding();
      test_age3();
      test_drain();
      test_reset_midop();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
